// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encoding and constants for the fetch controller
package fetch_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_STALL    = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_HALT     = 3'd4
    } state_e;
    localparam logic [31:0] SAT32 = 32'hFFFF_FFFF;
endpackage

// File: rtl/fetch_ctrl_sat.sv
// sat_counter: up-counter with synchronous clear and a flag raised at its ceiling
module sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             sat_o
);
    logic [WIDTH-1:0] count_q;
    assign count_o = count_q;
    assign sat_o   = count_q == MAX;
    // clear wins over enable; the caller gates the enable with sat_o to hold at MAX
    always_ff @(posedge clk) begin
        if (!reset_n || clr_i) count_q <= '0;
        else if (en_i)         count_q <= count_q + WIDTH'(1);
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences PC enable/select and the decode/execute stall and flush strobes
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 2,
    parameter int MAX_STALL   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall_req,
    input  logic        halt_req,
    output logic        pc_en,
    output logic        pc_src,
    output logic [31:0] pc_branch,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic        halted,
    output logic        stall_timeout,
    output logic [31:0] fetch_count
);
    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int SW = $clog2(MAX_STALL) + 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   init_q, init_d;
    logic [31:0]     pc_branch_q, pc_branch_d;
    logic            timeout_q, timeout_d;
    logic            stall_inc, stall_clr, stall_sat, stall_hit, fetch_sat;
    logic [SW-1:0]   stall_cnt;

    assign pc_branch     = pc_branch_q;
    assign halted        = state_q == ST_HALT;
    assign stall_hit     = stall_cnt >= SW'(MAX_STALL);
    assign stall_timeout = timeout_q | stall_hit;
    assign timeout_d     = stall_timeout;

    // decode strobes from state and live inputs; branch beats stall beats halt
    always_comb begin
        state_d     = state_q;
        init_d      = init_q;
        pc_branch_d = pc_branch_q;
        pc_en       = 1'b0;
        pc_src      = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        stall_inc   = 1'b0;
        stall_clr   = 1'b0;
        case (state_q)
            ST_INIT: begin
                flush_d = 1'b1;
                init_d  = (init_q == '0) ? init_q : init_q - IW'(1);
                state_d = (init_q == '0) ? ST_RUN : ST_INIT;
            end
            ST_RUN, ST_STALL: begin
                if (branch_taken) begin
                    flush_d     = 1'b1;
                    flush_e     = 1'b1;
                    pc_branch_d = branch_target;
                    stall_clr   = 1'b1;
                    state_d     = ST_REDIRECT;
                end else if (stall_req) begin
                    stall_d   = 1'b1;
                    flush_e   = 1'b1;
                    stall_inc = 1'b1;
                    state_d   = ST_STALL;
                end else if (state_q == ST_RUN && halt_req) begin
                    state_d = ST_HALT;
                end else begin
                    pc_en     = 1'b1;
                    stall_clr = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                pc_en   = 1'b1;
                pc_src  = 1'b1;
                flush_d = 1'b1;
                state_d = ST_RUN;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_INIT;
        endcase
    end

    // controller state, settle countdown, branch target latch and sticky timeout
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            init_q      <= IW'(INIT_CYCLES - 1);
            pc_branch_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            pc_branch_q <= pc_branch_d;
            timeout_q   <= timeout_d;
        end
    end

    sat_counter #(.WIDTH(32), .MAX(SAT32)) u_fetch_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (pc_en & ~fetch_sat),
        .clr_i   (1'b0),
        .count_o (fetch_count),
        .sat_o   (fetch_sat)
    );

    sat_counter #(.WIDTH(SW), .MAX(SW'(MAX_STALL))) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (stall_inc & ~stall_sat),
        .clr_i   (stall_clr),
        .count_o (stall_cnt),
        .sat_o   (stall_sat)
    );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a behavioural model
module tb_fetch_ctrl;
    localparam int INIT_CYCLES = 2;
    localparam int MAX_STALL   = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        stall_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        pc_en, pc_src, stall_d, flush_d, flush_e, halted, stall_timeout;
    logic [31:0] pc_branch, fetch_count;

    fetch_ctrl #(.INIT_CYCLES(INIT_CYCLES), .MAX_STALL(MAX_STALL)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall_req     (stall_req),
        .halt_req      (halt_req),
        .pc_en         (pc_en),
        .pc_src        (pc_src),
        .pc_branch     (pc_branch),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .halted        (halted),
        .stall_timeout (stall_timeout),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endfunction

    // behavioural model: what phase the controller is in, in plain terms
    int          m_init_left;
    bit          m_redir, m_halt, m_in_stall, m_to;
    int          m_scnt;
    logic [31:0] m_pcb;
    logic [31:0] m_cnt;

    typedef struct packed {
        logic pc_en, pc_src, stall_d, flush_d, flush_e, halted;
    } strobe_t;

    function automatic strobe_t expect_strobes();
        strobe_t s = '0;
        if (m_init_left > 0) s.flush_d = 1'b1;
        else if (m_redir) begin
            s.pc_en = 1'b1; s.pc_src = 1'b1; s.flush_d = 1'b1;
        end else if (m_halt) s.halted = 1'b1;
        else if (branch_taken) begin
            s.flush_d = 1'b1; s.flush_e = 1'b1;
        end else if (stall_req) begin
            s.stall_d = 1'b1; s.flush_e = 1'b1;
        end else if (!(halt_req && !m_in_stall)) s.pc_en = 1'b1;
        return s;
    endfunction

    always @(posedge clk) begin
        strobe_t e;
        e = expect_strobes();
        if (!reset_n) begin
            m_init_left <= INIT_CYCLES;
            m_redir <= 0; m_halt <= 0; m_in_stall <= 0; m_to <= 0;
            m_scnt <= 0; m_pcb <= '0; m_cnt <= '0;
        end else begin
            if (e.pc_en && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
            if (m_init_left > 0) m_init_left <= m_init_left - 1;
            else if (m_redir) m_redir <= 0;
            else if (m_halt) m_halt <= 1;
            else if (branch_taken) begin
                m_pcb <= branch_target; m_scnt <= 0; m_redir <= 1; m_in_stall <= 0;
            end else if (stall_req) begin
                m_in_stall <= 1;
                if (m_scnt < MAX_STALL) m_scnt <= m_scnt + 1;
                if (m_scnt + 1 >= MAX_STALL) m_to <= 1;
            end else if (!m_in_stall && halt_req) m_halt <= 1;
            else begin
                m_in_stall <= 0; m_scnt <= 0;
            end
        end
    end

    // every cycle, compare all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            strobe_t e;
            e = expect_strobes();
            chk("pc_en", pc_en, e.pc_en);
            chk("pc_src", pc_src, e.pc_src);
            chk("stall_d", stall_d, e.stall_d);
            chk("flush_d", flush_d, e.flush_d);
            chk("flush_e", flush_e, e.flush_e);
            chk("halted", halted, e.halted);
            chk("pc_branch", pc_branch, m_pcb);
            chk("stall_timeout", stall_timeout, m_to);
            chk("fetch_count", fetch_count, m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        reset_n = 1'b1;
        look(); chk("rst_c1_pc_en", pc_en, 0); chk("rst_c1_flush_d", flush_d, 1); chk("rst_c1_pc_src", pc_src, 0);
        step();
        look(); chk("rst_c2_pc_en", pc_en, 0); chk("rst_c2_flush_d", flush_d, 1);
        step();
        look(); chk("rst_c3_pc_en", pc_en, 1); chk("rst_c3_flush_d", flush_d, 0);
        step();
        branch_taken = 1'b1; branch_target = 32'h40;
        look(); chk("rst_fetch_count", fetch_count, 1);
        chk("br0_flush_d", flush_d, 1); chk("br0_flush_e", flush_e, 1); chk("br0_pc_en", pc_en, 0);
        step();
        branch_taken = 1'b0;
        look(); chk("br1_pc_src", pc_src, 1); chk("br1_pc_en", pc_en, 1); chk("br1_pc_branch", pc_branch, 32'h40);
        step();
        look(); chk("br2_pc_src", pc_src, 0); chk("br2_pc_en", pc_en, 1);
        step();
        stall_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            look(); chk("st_pc_en", pc_en, 0); chk("st_stall_d", stall_d, 1); chk("st_flush_e", flush_e, 1);
            step();
        end
        stall_req = 1'b0;
        look(); chk("st_rel_pc_en", pc_en, 1); chk("st_rel_stall_d", stall_d, 0); chk("st_timeout", stall_timeout, 0);
        step();
        stall_req = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
        look(); chk("sim_stall_d", stall_d, 0); chk("sim_flush_e", flush_e, 1); chk("sim_pc_en", pc_en, 0);
        step();
        stall_req = 1'b0; branch_target = 32'hC0;
        look(); chk("sim_redir_pc_src", pc_src, 1); chk("sim_pc_branch", pc_branch, 32'h80);
        step();
        branch_taken = 1'b0;
        look(); chk("sim_ign_pc_branch", pc_branch, 32'h80); chk("sim_ign_pc_src", pc_src, 0); chk("sim_ign_pc_en", pc_en, 1);
        step();
        stall_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            look();
            if (k == 15) chk("to_15", stall_timeout, 0);
            if (k == 16) chk("to_16", stall_timeout, 1);
        end
        step();
        stall_req = 1'b0;
        look(); chk("to_rel_pc_en", pc_en, 1); chk("to_rel_sticky", stall_timeout, 1);
        step();
        look(); chk("to_sticky", stall_timeout, 1);
        step();
        halt_req = 1'b1;
        look(); chk("halt0_pc_en", pc_en, 0); chk("halt0_halted", halted, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            look(); chk("halt_halted", halted, 1); chk("halt_pc_en", pc_en, 0);
            step();
        end
        halt_req = 1'b0; reset_n = 1'b0;
        look(); chk("halt_rst_halted", halted, 1);
        step();
        reset_n = 1'b1;
        look(); chk("hrst_halted", halted, 0); chk("hrst_pc_src", pc_src, 0);
        chk("hrst_fetch_count", fetch_count, 0); chk("hrst_timeout", stall_timeout, 0); chk("hrst_flush_d", flush_d, 1);
        step();
        look();
        step();
        branch_taken = 1'b1; branch_target = 32'h100;
        look();
        step();
        branch_taken = 1'b0; reset_n = 1'b0;
        look(); chk("rrst_redir_pc_src", pc_src, 1);
        step();
        reset_n = 1'b1;
        look(); chk("rrst_pc_src", pc_src, 0); chk("rrst_fetch_count", fetch_count, 0);
        chk("rrst_pc_en", pc_en, 0); chk("rrst_pc_branch", pc_branch, 0);
        step();
        for (int i = 0; i < 600; i++) begin
            reset_n       = m_halt ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 49) != 0);
            branch_taken  = $urandom_range(0, 5) == 0;
            branch_target = $urandom;
            stall_req     = $urandom_range(0, 2) == 0;
            halt_req      = $urandom_range(0, 24) == 0;
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the fetch stage of the ARM pipeline. It drives the PC write-enable and the PCSrc mux select, and latches the branch target.
It also generates the decode/execute stall and flush strobes for branch redirects, load-use stalls, startup settling and halt. It sits between the hazard/execute logic and the fetch datapath: mux, PC register, +4 adder and instruction memory.

Parameters:
INIT_CYCLES, 2, cycles PC is held after reset while instruction memory settles (min 1)
MAX_STALL, 16, consecutive stall cycles after which stall_timeout is set (min 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous, active-low reset
branch_taken  input  1  execute stage resolved a taken branch this cycle
branch_target  input  32  branch destination, valid with branch_taken
stall_req  input  1  load-use hazard request from hazard unit (level)
halt_req  input  1  stop fetching (level, sampled in RUN only)
pc_en  output  1  PC register write enable
pc_src  output  1  fetch mux select: 0 = PC+4, 1 = pc_branch
pc_branch  output  32  registered branch target fed to the fetch mux
stall_d  output  1  hold IF/ID register
flush_d  output  1  clear IF/ID register
flush_e  output  1  clear ID/EX register
halted  output  1  controller is in HALT
stall_timeout  output  1  sticky error: stall lasted MAX_STALL cycles
fetch_count  output  32  number of cycles with pc_en=1, saturating

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low. reset_n=0 at an edge forces INIT on the next cycle from any state, including mid-stall or mid-redirect.
- Reset values: state=INIT, init counter=INIT_CYCLES-1, pc_branch=0, stall counter=0, stall_timeout=0, fetch_count=0.
- Outputs right after reset: pc_en=0, pc_src=0, flush_d=1, flush_e=0, stall_d=0, halted=0.
- States: INIT, RUN, STALL, REDIRECT, HALT. Outputs are a decode of the state plus the current inputs.
- INIT: pc_en=0, flush_d=1, all other strobes 0. Stays INIT_CYCLES cycles, then moves to RUN. All inputs are ignored.
- RUN/STALL priority, highest first: branch_taken > stall_req > halt_req (halt_req is honoured in RUN only).
- branch_taken (RUN or STALL):
  - Same cycle: pc_en=0, stall_d=0, flush_d=1, flush_e=1.
  - pc_branch<=branch_target; stall counter cleared; next state REDIRECT.
- stall_req (no branch):
  - Same cycle: pc_en=0, stall_d=1, flush_e=1 (bubble into execute); next state STALL.
  - The stall counter increments each stalled cycle, with the first stalled cycle counting 1.
  - When the counter reaches MAX_STALL, stall_timeout<=1. It stays set until reset, and the counter saturates.
- STALL exit: stall_req=0 gives pc_en=1 and stall_d=0 in that same cycle, counter cleared, next state RUN.
- halt_req (RUN, no branch, no stall): pc_en=0 that cycle, next state HALT.
- RUN otherwise: pc_en=1, pc_src=0, all strobes 0.
- REDIRECT: exactly 1 cycle, then RUN.
  - pc_en=1, pc_src=1, flush_d=1 (squashes the wrong-path instruction); PC loads pc_branch.
  - branch_taken, stall_req and halt_req are ignored (the wrong-path source is being flushed).
- HALT: pc_en=0, halted=1, strobes 0. Only reset exits.
- fetch_count increments in every cycle with pc_en=1 and saturates at 32'hFFFFFFFF.
- Latencies:
  - Branch: branch_taken to PC==target is 2 edges.
  - Stall release: stall_req falling to PC advance is 1 edge.
  - Reset: reset_n release to first PC advance is INIT_CYCLES+1 edges.

Decomposition:
- Shared package: state encoding constants (3-bit, INIT=0, RUN=1, STALL=2, REDIRECT=3, HALT=4) and a 32-bit all-ones saturation constant.
- One natural sub-module, sat_counter: parameterised width, enable, synchronous clear, saturate flag.
  - Used for fetch_count (32-bit).
  - Used for the stall counter (width = clog2(MAX_STALL)+1).

Test Plan:
- Reset hold: reset_n=0 for 3 cycles, then 1 -> pc_en=0 and flush_d=1 for 2 cycles; pc_en=1 on cycle 3; fetch_count=1 after cycle 3.
- Taken branch: RUN, branch_taken=1 with target 32'h0000_0040 for 1 cycle.
  - Cycle 0: flush_d=flush_e=1, pc_en=0.
  - Cycle 1: pc_src=1, pc_en=1, pc_branch=0x40.
  - Cycle 2: RUN with pc_src=0.
- Stall: stall_req=1 for 3 cycles -> pc_en=0, stall_d=1, flush_e=1 for 3 cycles; the 4th cycle gives pc_en=1, stall_d=0; stall_timeout stays 0.
- Simultaneous events: stall_req=1 and branch_taken=1 (target 0x80) in the same cycle -> redirect path wins, stall_d=0, REDIRECT next with pc_branch=0x80. A branch_taken during REDIRECT is ignored.
- Timeout: stall_req held 16 cycles -> stall_timeout=1 after the 16th stalled edge. It stays 1 after the stall releases, and clears only on reset.
- Halt and mid-operation reset: halt_req=1 in RUN -> halted=1, pc_en=0 thereafter. Asserting reset_n=0 during HALT or REDIRECT -> INIT next cycle, halted=0, pc_src=0, fetch_count=0.
